// File: rtl/dmem_responder_if.sv
// Memory-stage bus between the MIPS core and dmem_responder, plus the console TX drain port.
// The misalign flag exists only when DMEM_ALIGN_CHECK_EN is defined.
interface dmem_responder_if;
  logic        MemWrite_M;
  logic [31:0] ALUResult_M;
  logic [31:0] WriteData_M;
  logic [31:0] ReadData_M;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        misalign;

  modport master (
    output MemWrite_M, ALUResult_M, WriteData_M, tx_ready,
    input  ReadData_M, tx_valid, tx_data, misalign
  );
  modport slave (
    input  MemWrite_M, ALUResult_M, WriteData_M, tx_ready,
    output ReadData_M, tx_valid, tx_data, misalign
  );
`else
  modport master (
    output MemWrite_M, ALUResult_M, WriteData_M, tx_ready,
    input  ReadData_M, tx_valid, tx_data
  );
  modport slave (
    input  MemWrite_M, ALUResult_M, WriteData_M, tx_ready,
    output ReadData_M, tx_valid, tx_data
  );
`endif
endinterface

// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM with async read, cycle counter, console TX FIFO, status.
// Optional macro DMEM_ALIGN_CHECK_EN adds a sticky misalign flag and suppresses misaligned stores.
module dmem_responder #(
  parameter int RAM_DEPTH  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  dmem_responder_if.slave bus
);
  localparam int RAM_AW  = $clog2(RAM_DEPTH);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;

  // Word addresses of the MMIO registers (byte address >> 2).
  localparam logic [29:0] CYCLE_WA  = 30'h3FFF_C000;
  localparam logic [29:0] TXDATA_WA = 30'h3FFF_C001;
  localparam logic [29:0] STATUS_WA = 30'h3FFF_C002;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_CYCLE,
    REG_TXDATA,
    REG_STATUS
  } region_e;

  logic [29:0]       word_addr;
  logic [RAM_AW-1:0] ram_idx;
  region_e           region;
  logic              store_en;

  assign word_addr = bus.ALUResult_M[31:2];
  assign ram_idx   = word_addr[RAM_AW-1:0];

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    region = REG_NONE;
    if (bus.ALUResult_M[31:16] == 16'h0000 && 32'(word_addr) < RAM_DEPTH) begin
      region = REG_RAM;
    end else begin
      case (word_addr)
        CYCLE_WA:  region = REG_CYCLE;
        TXDATA_WA: region = REG_TXDATA;
        STATUS_WA: region = REG_STATUS;
        default:   region = REG_NONE;
      endcase
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic aligned;
  logic misalign_set;
  logic misalign_q;

  assign aligned      = (bus.ALUResult_M[1:0] == 2'b00);
  assign store_en     = bus.MemWrite_M && aligned;
  assign misalign_set = !aligned && (bus.MemWrite_M || region == REG_RAM);

  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_q | misalign_set;
  end

  assign bus.misalign = misalign_q;
`else
  assign store_en = bus.MemWrite_M;
`endif

  // ---------------------------------------------------------------- RAM
  logic [31:0] ram [RAM_DEPTH];

  // NOTE: storage arrays are deliberately left out of reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (store_en && region == REG_RAM) ram[ram_idx] <= bus.WriteData_M;
  end

  // ------------------------------------------------------ cycle counter
  logic [31:0] cycle_q;

  // NOTE: clocked state uses <= only, so every update in this edge sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)                                cycle_q <= 32'h0;
    else if (store_en && region == REG_CYCLE) cycle_q <= 32'h0;
    else                                      cycle_q <= cycle_q + 32'h1;
  end

  // ------------------------------------------------------ console TX FIFO
  logic [7:0]         fifo [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               push_req;
  logic               push;
  logic               overflow;
  logic               status_clr;
  logic               ovf_q;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign pop        = !fifo_empty && bus.tx_ready;
  assign push_req   = store_en && region == REG_TXDATA;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push       = push_req && (!fifo_full || pop);
  assign overflow   = push_req && !push;
  assign status_clr = store_en && region == REG_STATUS && bus.WriteData_M[2];

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= bus.WriteData_M[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (overflow)        ovf_q <= 1'b1;
      else if (status_clr) ovf_q <= 1'b0;
    end
  end

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_empty ? 8'h00 : fifo[rd_ptr];

  // ------------------------------------------------------------ read mux
  logic [31:0] status_word;

  assign status_word = {16'h0000, 8'(count), 5'b00000, ovf_q, fifo_full, fifo_empty};

  always_comb begin
    bus.ReadData_M = 32'h0;
    case (region)
      REG_RAM:    bus.ReadData_M = ram[ram_idx];
      REG_CYCLE:  bus.ReadData_M = cycle_q;
      REG_STATUS: bus.ReadData_M = status_word;
      default:    bus.ReadData_M = 32'h0;
    endcase
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side memory responder for the pipelined MIPS core; it is the far end of the core's memory-stage port.
- Serves word loads combinationally in the same cycle and commits stores at the clock edge.
- Decodes a small MMIO window: a free-running cycle counter, a console TX FIFO with a valid/ready drain port, and a status register.
- Sits beside the core in the top level, wired to ALUResult_M, WriteData_M, MemWrite_M and ReadData_M.

Parameters:
RAM_DEPTH, 256, number of 32-bit words in data RAM; power of 2.
FIFO_DEPTH, 8, console TX FIFO entries; power of 2, minimum 2.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
MemWrite_M  in  1  store strobe from core memory stage.
ALUResult_M  in  32  byte address from core.
WriteData_M  in  32  store data from core.
ReadData_M  out  32  load data to core; combinational from address.
tx_valid  out  1  FIFO non-empty.
tx_data  out  8  FIFO head byte.
tx_ready  in  1  consumer accepts head this cycle.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Address decode, word-granular, ALUResult_M[1:0] ignored:
  - RAM: ALUResult_M[31:16]==0 and word index < RAM_DEPTH.
  - CYCLE: 0xFFFF0000.
  - TXDATA: 0xFFFF0004.
  - STATUS: 0xFFFF0008.
  - Any other address: reads return 0; writes are ignored.
- RAM:
  - Asynchronous read; ReadData_M tracks the address in the same cycle.
  - Write is committed at posedge when MemWrite_M=1.
  - A read of the address being written returns the old data until the edge.
  - RAM contents are not reset.
- CYCLE:
  - Increments every cycle; wraps 0xFFFFFFFF->0.
  - A store to CYCLE loads 0 at the edge; the clear wins over the increment.
  - Reads return the current value.
- TXDATA:
  - A store pushes WriteData_M[7:0] into the FIFO.
  - The push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A rejected push drops the byte and sets the sticky ovf bit.
  - Reads of TXDATA return 0.
- FIFO:
  - tx_valid = count!=0; tx_data = head entry.
  - Pop at posedge when tx_valid && tx_ready.
  - No bypass: a byte pushed into an empty FIFO appears on tx_valid the next cycle.
  - Simultaneous push and pop leaves count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- STATUS read:
  - [0] empty, [1] full, [2] ovf.
  - [15:8] count, zero-extended.
  - All other bits 0.
- STATUS write: WriteData_M[2]=1 clears ovf. If an overflow occurs in the same cycle, set wins.
- Reset (next edge): CYCLE=0, FIFO pointers/count=0, ovf=0. Consequently tx_valid=0 and tx_data=0, driven as 0 when the FIFO is empty.
- Reset during a pending push or pop discards the FIFO contents. RAM is unaffected.
- ReadData_M after reset:
  - Combinational.
  - CYCLE reads 0.
  - STATUS reads 0x00000001.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN adds output misalign (1 bit, sticky).
- With the macro defined:
  - misalign sets when MemWrite_M=1 and ALUResult_M[1:0]!=0.
  - It also sets when MemWrite_M=0 and the address decodes to RAM with [1:0]!=0.
  - Cleared only by reset.
  - A misaligned store is suppressed: no RAM write, no FIFO push, no CYCLE clear.
- Without the macro: no misalign port, and [1:0] is silently ignored.

Test Plan:
- Store 0xDEADBEEF to 0x00000010, then load 0x00000010 -> ReadData_M=0xDEADBEEF. Load 0x00000400 (index 256, out of range) -> 0.
- Release reset, wait 5 cycles, load 0xFFFF0000 -> 5. Store to CYCLE -> next cycle reads 0, then 1. Preload 0xFFFFFFFF via hierarchical force -> wraps to 0.
- tx_ready=0, push 0x41..0x48 (8 bytes) -> STATUS=0x00000802 (full, count 8). 9th push 0x49 -> dropped, STATUS bit2=1. Store 0x4 to STATUS -> ovf cleared.
- With the FIFO full, push 0x5A while tx_ready=1 -> accepted, count stays 8, ovf stays 0. Drain -> tx_data sequence 0x42..0x48 then 0x5A.
- Push 0x61 into an empty FIFO -> tx_valid=0 in the push cycle, 1 the next cycle. Assert reset with 3 bytes queued -> after the edge tx_valid=0 and STATUS=0x00000001.
- DMEM_ALIGN_CHECK_EN: store 0x12345678 to 0x00000011 -> misalign=1 and RAM word 4 unchanged. Misalign stays 1 until reset.
